// File: rtl/legv8_ctrl_pkg.sv
// Shared definitions for the LEGv8 multicycle control unit.
//   - state_t       : sequencing states (RST, FETCH, DECODE, EXECUTE, HALT)
//   - insn_class_t  : instruction classes recognised by the decoder
//   - OP_*          : opcode field values (11/10/8/6-bit, aligned at IR[31])
//   - FS_*          : ALU function-select codes, as the datapath ALU encodes them
//   - PS_*/DS_*/AS_*: PC-select, data-select and address-select encodings
//   - CW_*          : bit offsets of each ControlWord field
//   - classify()    : maps an instruction word to its class
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE, CL_ADD, CL_SUB, CL_AND, CL_ORR, CL_ADDS, CL_SUBS,
    CL_ADDI, CL_SUBI, CL_LDUR, CL_STUR, CL_B, CL_CBZ, CL_CBNZ, CL_BCOND
  } insn_class_t;

  localparam logic [10:0] OP_ADD   = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUB   = 11'b110_0101_1000;
  localparam logic [10:0] OP_AND   = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORR   = 11'b101_0101_0000;
  localparam logic [10:0] OP_ADDS  = 11'b101_0101_1000;
  localparam logic [10:0] OP_SUBS  = 11'b111_0101_1000;
  localparam logic [10:0] OP_LDUR  = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR  = 11'b111_1100_0000;
  localparam logic [9:0]  OP_ADDI  = 10'b10_0100_0100;
  localparam logic [9:0]  OP_SUBI  = 10'b11_0100_0100;
  localparam logic [7:0]  OP_CBZ   = 8'b1011_0100;
  localparam logic [7:0]  OP_CBNZ  = 8'b1011_0101;
  localparam logic [7:0]  OP_BCOND = 8'b0101_0100;
  localparam logic [5:0]  OP_B     = 6'b00_0101;

  localparam logic [4:0] FS_AND    = 5'b00000;
  localparam logic [4:0] FS_ORR    = 5'b00100;
  localparam logic [4:0] FS_ADD    = 5'b01000;
  localparam logic [4:0] FS_SUB    = 5'b01001;
  localparam logic [4:0] FS_PASS_B = 5'b10100;

  localparam logic [1:0] PS_HOLD  = 2'b00;
  localparam logic [1:0] PS_INC   = 2'b01;
  localparam logic [1:0] PS_PC_K  = 2'b10;

  localparam logic [1:0] DS_ALU   = 2'b00;
  localparam logic [1:0] DS_STORE = 2'b01;
  localparam logic [1:0] DS_MEM   = 2'b11;

  localparam logic AS_ALU = 1'b0;
  localparam logic AS_PC  = 1'b1;

  localparam int CW_SB    = 0;
  localparam int CW_SA    = 5;
  localparam int CW_DA    = 10;
  localparam int CW_RW    = 15;
  localparam int CW_MW    = 16;
  localparam int CW_SIZE  = 17;
  localparam int CW_C0    = 19;
  localparam int CW_FS    = 20;
  localparam int CW_SL    = 25;
  localparam int CW_IL    = 26;
  localparam int CW_BSEL  = 27;
  localparam int CW_PCSEL = 28;
  localparam int CW_PS    = 29;
  localparam int CW_DS    = 31;
  localparam int CW_AS    = 33;
  localparam int CW_WIDTH = 34;

  // Widest opcode fields are tested first so a short opcode never shadows a
  // longer one that shares its leading bits.
  function automatic insn_class_t classify(input logic [31:0] ir);
    insn_class_t cls;
    cls = CL_NONE;
    case (ir[31:21])
      OP_ADD:  cls = CL_ADD;
      OP_SUB:  cls = CL_SUB;
      OP_AND:  cls = CL_AND;
      OP_ORR:  cls = CL_ORR;
      OP_ADDS: cls = CL_ADDS;
      OP_SUBS: cls = CL_SUBS;
      OP_LDUR: cls = CL_LDUR;
      OP_STUR: cls = CL_STUR;
      default: begin
        if (ir[31:22] == OP_ADDI)       cls = CL_ADDI;
        else if (ir[31:22] == OP_SUBI)  cls = CL_SUBI;
        else if (ir[31:24] == OP_CBZ)   cls = CL_CBZ;
        else if (ir[31:24] == OP_CBNZ)  cls = CL_CBNZ;
        else if (ir[31:24] == OP_BCOND) cls = CL_BCOND;
        else if (ir[31:26] == OP_B)     cls = CL_B;
      end
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/legv8_imm_gen.sv
// Immediate extraction/extension for the LEGv8 control unit.
//   field : IR[25:0], the part of the instruction that holds every immediate
//   cls   : decoded instruction class
//   imm   : 64-bit constant for the datapath B-mux / PC adder
// Branch offsets are reduced by 4 because PC has already advanced in FETCH.
module legv8_imm_gen
  import legv8_ctrl_pkg::*;
(
  input  logic [25:0]  field,
  input  insn_class_t  cls,
  output logic [63:0]  imm
);

  function automatic logic signed [63:0] sext9(input logic [8:0] v);
    return {{55{v[8]}}, v};
  endfunction

  function automatic logic signed [63:0] sext21(input logic [20:0] v);
    return {{43{v[20]}}, v};
  endfunction

  function automatic logic signed [63:0] sext28(input logic [27:0] v);
    return {{36{v[27]}}, v};
  endfunction

  logic signed [63:0] b_off;
  logic signed [63:0] cb_off;

  assign b_off  = sext28({field[25:0], 2'b00}) - 64'sd4;
  assign cb_off = sext21({field[23:5], 2'b00}) - 64'sd4;

  always_comb begin
    imm = '0;
    case (cls)
      CL_ADDI, CL_SUBI:          imm = {52'd0, field[21:10]};
      CL_LDUR, CL_STUR:          imm = sext9(field[20:12]);
      CL_B:                      imm = b_off;
      CL_CBZ, CL_CBNZ, CL_BCOND: imm = cb_off;
      default:                   imm = '0;
    endcase
  end

endmodule

// File: rtl/legv8_control_unit.sv
// Multicycle FETCH -> DECODE -> EXECUTE control unit for the LEGv8 datapath.
//   clock        : system clock, rising edge
//   reset        : asynchronous, active-low
//   IR_out       : instruction register contents from the datapath
//   status       : [4:1] stored {V,C,N,Z}, [0] live ALU zero
//   ControlWord  : 34-bit datapath control word
//   constant     : 64-bit immediate for B-mux / PC adder
//   halted       : high while in HALT
//   insn_retired : count of completed EXECUTE cycles (wraps)
module legv8_control_unit
  import legv8_ctrl_pkg::*;
#(
  parameter int INSN_COUNT_WIDTH = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [31:0]                 IR_out,
  input  logic [4:0]                  status,
  output logic [33:0]                 ControlWord,
  output logic [63:0]                 constant,
  output logic                        halted,
  output logic [INSN_COUNT_WIDTH-1:0] insn_retired
);

  state_t      state, state_nxt;
  insn_class_t cls;
  logic [63:0] imm;

  assign cls = classify(IR_out);

  legv8_imm_gen u_imm_gen (
    .field (IR_out[25:0]),
    .cls   (cls),
    .imm   (imm)
  );

  // flags = {V,C,N,Z}; unlisted conditions are never taken.
  function automatic logic cond_taken(input logic [3:0] cond, input logic [3:0] flags);
    logic v, c, n, z;
    {v, c, n, z} = flags;
    case (cond)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return c;
      4'h3:    return !c;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z && (n == v);
      4'hD:    return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_RST;
      insn_retired <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_EXECUTE) insn_retired <= insn_retired + INSN_COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:     state_nxt = ST_FETCH;
      ST_FETCH:   state_nxt = ST_DECODE;
      ST_DECODE:  state_nxt = (cls == CL_NONE) ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE: state_nxt = ST_FETCH;
      ST_HALT:    state_nxt = ST_HALT;
      default:    state_nxt = ST_RST;
    endcase
  end

  assign halted = (state == ST_HALT);

  // Outputs are purely combinational from state and IR_out, so an async
  // reset idles the datapath in the same cycle it is asserted.
  logic       as_f, pcsel_f, bsel_f, il_f, sl_f, c0_f, mw_f, rw_f;
  logic [1:0] ds_f, ps_f, size_f;
  logic [4:0] fs_f, da_f, sa_f, sb_f;

  always_comb begin
    as_f = 1'b0; ds_f = DS_ALU; ps_f = PS_HOLD; pcsel_f = 1'b0; bsel_f = 1'b0;
    il_f = 1'b0; sl_f = 1'b0; fs_f = '0; c0_f = 1'b0; size_f = 2'b00;
    mw_f = 1'b0; rw_f = 1'b0; da_f = '0; sa_f = '0; sb_f = '0;
    constant = '0;
    case (state)
      ST_FETCH: begin
        as_f = AS_PC; ds_f = DS_MEM; il_f = 1'b1; ps_f = PS_INC; size_f = 2'b11;
      end
      ST_EXECUTE: begin
        da_f = IR_out[4:0]; sa_f = IR_out[9:5]; sb_f = IR_out[20:16];
        constant = imm;
        case (cls)
          CL_ADD:  begin fs_f = FS_ADD; rw_f = 1'b1; end
          CL_SUB:  begin fs_f = FS_SUB; c0_f = 1'b1; rw_f = 1'b1; end
          CL_AND:  begin fs_f = FS_AND; rw_f = 1'b1; end
          CL_ORR:  begin fs_f = FS_ORR; rw_f = 1'b1; end
          CL_ADDS: begin fs_f = FS_ADD; sl_f = 1'b1; rw_f = 1'b1; end
          CL_SUBS: begin fs_f = FS_SUB; c0_f = 1'b1; sl_f = 1'b1; rw_f = 1'b1; end
          CL_ADDI: begin fs_f = FS_ADD; bsel_f = 1'b1; rw_f = 1'b1; end
          CL_SUBI: begin fs_f = FS_SUB; c0_f = 1'b1; bsel_f = 1'b1; rw_f = 1'b1; end
          CL_LDUR: begin
            as_f = AS_ALU; ds_f = DS_MEM; bsel_f = 1'b1; fs_f = FS_ADD;
            rw_f = 1'b1; size_f = 2'b11;
          end
          CL_STUR: begin
            as_f = AS_ALU; ds_f = DS_STORE; bsel_f = 1'b1; fs_f = FS_ADD;
            sb_f = IR_out[4:0]; mw_f = 1'b1; size_f = 2'b11;
          end
          CL_B: begin ps_f = PS_PC_K; pcsel_f = 1'b1; end
          // Rt is passed through the ALU; status[0] is its live zero flag.
          CL_CBZ: begin
            fs_f = FS_PASS_B; sb_f = IR_out[4:0];
            ps_f = status[0] ? PS_PC_K : PS_HOLD;
          end
          CL_CBNZ: begin
            fs_f = FS_PASS_B; sb_f = IR_out[4:0];
            ps_f = status[0] ? PS_HOLD : PS_PC_K;
          end
          CL_BCOND: ps_f = cond_taken(IR_out[3:0], status[4:1]) ? PS_PC_K : PS_HOLD;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    ControlWord                  = '0;
    ControlWord[CW_AS]           = as_f;
    ControlWord[CW_DS +: 2]      = ds_f;
    ControlWord[CW_PS +: 2]      = ps_f;
    ControlWord[CW_PCSEL]        = pcsel_f;
    ControlWord[CW_BSEL]         = bsel_f;
    ControlWord[CW_IL]           = il_f;
    ControlWord[CW_SL]           = sl_f;
    ControlWord[CW_FS +: 5]      = fs_f;
    ControlWord[CW_C0]           = c0_f;
    ControlWord[CW_SIZE +: 2]    = size_f;
    ControlWord[CW_MW]           = mw_f;
    ControlWord[CW_RW]           = rw_f;
    ControlWord[CW_DA +: 5]      = da_f;
    ControlWord[CW_SA +: 5]      = sa_f;
    ControlWord[CW_SB +: 5]      = sb_f;
  end

endmodule

// File: tb/tb_legv8_control_unit.sv
// Scoreboard bench for legv8_control_unit: the driver pushes the expected
// outputs for each cycle it cares about; a negedge monitor pops and compares.
module tb_legv8_control_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] IR_out;
  logic [4:0]  status;
  logic [33:0] ControlWord;
  logic [63:0] constant;
  logic        halted;
  logic [31:0] insn_retired;

  legv8_control_unit #(.INSN_COUNT_WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .IR_out       (IR_out),
    .status       (status),
    .ControlWord  (ControlWord),
    .constant     (constant),
    .halted       (halted),
    .insn_retired (insn_retired)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] cyc;
    logic [95:0] name;
    logic [33:0] cw;
    logic [63:0] k;
    logic        h;
    logic [31:0] r;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_ret = 0;

  // Field order: AS DS PS PCsel Bsel IL SL FS C0 size MW RW DA SA SB
  function automatic logic [33:0] mk(
    input logic as, input logic [1:0] ds, input logic [1:0] ps,
    input logic pcsel, input logic bsel, input logic il, input logic sl,
    input logic [4:0] fs, input logic c0, input logic [1:0] size,
    input logic mw, input logic rw,
    input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb);
    return {as, ds, ps, pcsel, bsel, il, sl, fs, c0, size, mw, rw, da, sa, sb};
  endfunction

  logic [33:0] cw_fetch;
  initial cw_fetch = mk(1, 2'b11, 2'b01, 0, 0, 1, 0, 5'd0, 0, 2'b11, 0, 0, 5'd0, 5'd0, 5'd0);

  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input logic [95:0] name, input logic [33:0] cw,
                            input logic [63:0] k, input logic h, input logic [31:0] r);
    exp_t e;
    e.cyc = cyc; e.name = name; e.cw = cw; e.k = k; e.h = h; e.r = r;
    q.push_back(e);
  endtask

  // Starts in the cycle before FETCH (RST or a previous EXECUTE).
  task automatic run_insn(input logic [95:0] name, input logic [31:0] ir,
                          input logic [4:0] st, input logic [33:0] cw_exec,
                          input logic [63:0] k_exec);
    tick(); IR_out = ir; status = st;
    expect_out("fetch", cw_fetch, 64'd0, 1'b0, exp_ret);
    tick();
    expect_out("decode", 34'd0, 64'd0, 1'b0, exp_ret);
    tick();
    expect_out(name, cw_exec, k_exec, 1'b0, exp_ret);
    exp_ret = exp_ret + 1;
  endtask

  // Monitor
  initial forever begin
    exp_t e;
    @(negedge clock);
    while (q.size() > 0 && int'(q[0].cyc) <= cyc) begin
      e = q.pop_front();
      n_checks = n_checks + 1;
      if (int'(e.cyc) != cyc)
        $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.name, e.cyc, cyc);
      else if (ControlWord !== e.cw || constant !== e.k || halted !== e.h || insn_retired !== e.r)
        $display("FAIL %s: got cw=%h k=%h halted=%b ret=%0d, want cw=%h k=%h halted=%b ret=%0d",
                 e.name, ControlWord, constant, halted, insn_retired, e.cw, e.k, e.h, e.r);
      else
        n_pass = n_pass + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; IR_out = 32'd0; status = 5'd0;
    tick(); expect_out("rst_hold", 34'd0, 64'd0, 1'b0, 32'd0);
    tick(); reset = 1'b1;
    expect_out("rst_cycle", 34'd0, 64'd0, 1'b0, 32'd0);

    run_insn("addi", 32'h910017E1, 5'b00000,
             mk(0, 2'b00, 2'b00, 0, 1, 0, 0, 5'b01000, 0, 2'b00, 0, 1, 5'd1, 5'd31, 5'd0), 64'd5);
    run_insn("subs", 32'hEB090107, 5'b00000,
             mk(0, 2'b00, 2'b00, 0, 0, 0, 1, 5'b01001, 1, 2'b00, 0, 1, 5'd7, 5'd8, 5'd9), 64'd0);
    run_insn("ldur", 32'hF85F8062, 5'b00000,
             mk(0, 2'b11, 2'b00, 0, 1, 0, 0, 5'b01000, 0, 2'b11, 0, 1, 5'd2, 5'd3, 5'd31),
             64'hFFFF_FFFF_FFFF_FFF8);
    run_insn("stur", 32'hF80000C5, 5'b00000,
             mk(0, 2'b01, 2'b00, 0, 1, 0, 0, 5'b01000, 0, 2'b11, 1, 0, 5'd5, 5'd6, 5'd5), 64'd0);
    run_insn("b_back", 32'h17FFFFFF, 5'b00000,
             mk(0, 2'b00, 2'b10, 1, 0, 0, 0, 5'd0, 0, 2'b00, 0, 0, 5'd31, 5'd31, 5'd31),
             64'hFFFF_FFFF_FFFF_FFF8);
    run_insn("cbz_taken", 32'hB4000084, 5'b00001,
             mk(0, 2'b00, 2'b10, 0, 0, 0, 0, 5'b10100, 0, 2'b00, 0, 0, 5'd4, 5'd4, 5'd4), 64'd12);
    run_insn("cbz_not", 32'hB4000084, 5'b00000,
             mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 5'b10100, 0, 2'b00, 0, 0, 5'd4, 5'd4, 5'd4), 64'd12);
    run_insn("beq_taken", 32'h54000040, 5'b00010,
             mk(0, 2'b00, 2'b10, 0, 0, 0, 0, 5'd0, 0, 2'b00, 0, 0, 5'd0, 5'd2, 5'd0), 64'd4);
    run_insn("beq_not", 32'h54000040, 5'b00000,
             mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 0, 2'b00, 0, 0, 5'd0, 5'd2, 5'd0), 64'd4);
    run_insn("bgt_taken", 32'h5400004C, 5'b00000,
             mk(0, 2'b00, 2'b10, 0, 0, 0, 0, 5'd0, 0, 2'b00, 0, 0, 5'd12, 5'd2, 5'd0), 64'd4);
    run_insn("blo_not", 32'h54000043, 5'b01000,
             mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 0, 2'b00, 0, 0, 5'd3, 5'd2, 5'd0), 64'd4);

    // Asynchronous reset in the middle of FETCH.
    tick(); reset = 1'b0; exp_ret = 0;
    expect_out("rst_mid_fetch", 34'd0, 64'd0, 1'b0, 32'd0);
    tick(); reset = 1'b1;
    expect_out("rst_cycle2", 34'd0, 64'd0, 1'b0, 32'd0);

    // Illegal instruction: FETCH, DECODE, then sticky HALT.
    tick(); IR_out = 32'h0000_0000; status = 5'd0;
    expect_out("fetch_ill", cw_fetch, 64'd0, 1'b0, 32'd0);
    tick();
    expect_out("decode_ill", 34'd0, 64'd0, 1'b0, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_out("halt_hold", 34'd0, 64'd0, 1'b1, 32'd0);
    end
    tick(); reset = 1'b0;
    expect_out("halt_clear", 34'd0, 64'd0, 1'b0, 32'd0);
    tick(); reset = 1'b1;

    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    if (q.size() != 0) begin
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      n_checks = n_checks + q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
